// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 32-bit memory port between the cpu (port C) and the
// loader/DMA engine (port D) using a req/ack handshake per port.
// Each access runs IDLE -> ISSUE -> WAIT (LAT cycles) -> ACK -> IDLE. The
// winner's command is latched at grant time. mem_en is a one-cycle strobe, and
// the ack is a one-cycle pulse to the owning port.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to break C/D ties round-robin
// (the port that did not own the last access wins). Without it, C always wins
// ties, and D is granted only when C is not requesting.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clock,
  input  logic              reset,
  // cpu port
  input  logic              c_req,
  input  logic              c_rw,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ack,
  // loader/DMA port
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  // memory port
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  // The wait counter is 4 bits wide, so LAT must fit in 1..15.
  localparam logic [3:0] LAT_CNT = 4'(LAT);

  if (LAT < 1 || LAT > 15) begin : g_lat_check
    $error("mem_arbiter: LAT=%0d is outside the legal range 1..15", LAT);
  end

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              owner_reg;
  logic              busy_reg;
  logic [1:0]        ack_reg;        // index 0 = C, 1 = D
  logic [DATA_W-1:0] rdata_reg [2];  // index 0 = C, 1 = D
  logic              mem_en_reg;
  logic              mem_rw_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              last_owner_reg;
`endif

  logic              grant_any;
  logic              winner;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Pick the winning port and steer its command toward the mem_* registers.
  always_comb begin
    grant_any = c_req | d_req;
    winner    = ~c_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (c_req && d_req) begin
      winner = ~last_owner_reg;
    end
`endif
    sel_rw    = winner ? d_rw    : c_rw;
    sel_addr  = winner ? d_addr  : c_addr;
    sel_wdata = winner ? d_wdata : c_wdata;
  end

  // Access sequencer. All outputs are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      owner_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      ack_reg       <= 2'b00;
      rdata_reg[0]  <= '0;
      rdata_reg[1]  <= '0;
      mem_en_reg    <= 1'b0;
      mem_rw_reg    <= 1'b1;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_reg <= 1'b1;
`endif
    end else begin
      // Strobes are single-cycle unless set again below.
      mem_en_reg <= 1'b0;
      ack_reg    <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            mem_rw_reg    <= sel_rw;
            mem_addr_reg  <= sel_addr;
            mem_wdata_reg <= sel_wdata;
            owner_reg     <= winner;
            mem_en_reg    <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg   <= LAT_CNT;
          state_reg <= WAIT;
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            // Memory data is valid in this cycle. Only a read updates the owner's register.
            if (mem_rw_reg) begin
              rdata_reg[owner_reg] <= mem_rdata;
            end
            ack_reg[owner_reg] <= 1'b1;
            state_reg          <= ACK;
          end
        end
        ACK: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_owner_reg <= owner_reg;
`endif
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign c_rdata   = rdata_reg[0];
  assign d_rdata   = rdata_reg[1];
  assign c_ack     = ack_reg[0];
  assign d_ack     = ack_reg[1];
  assign mem_en    = mem_en_reg;
  assign mem_rw    = mem_rw_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = busy_reg;
  assign owner     = owner_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized two-port traffic against mem_arbiter.
// The reference model is transaction-level. It records each grant cycle T and
// derives all output timing from that cycle: issue at T+1, ack at T+LAT+2,
// busy from T+1 through T+LAT+2, and a new grant no earlier than T+LAT+3.
// Read data comes from a reference memory array.
module tb_mem_arbiter;
  localparam int LAT  = 3;
  localparam int NCYC = 4000;

  logic        clock = 1'b0;
  logic        reset;
  logic        c_req, c_rw, d_req, d_rw;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [31:0] c_rdata, d_rdata;
  logic        c_ack, d_ack;
  logic        mem_en, mem_rw;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, owner;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_rw(c_rw), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cur_cyc = 0;
  int n_txn = 0;

  // memory as seen by the DUT, and the reference copy used by the model
  logic [31:0] mem_arr   [16];
  logic [31:0] model_mem [16];
  int          resp_cycle = -1;
  logic [31:0] resp_data = '0;

  // reference model state
  bit          m_active;
  int          m_gt;
  bit          m_port, m_rw, m_last;
  logic [31:0] m_addr, m_wdata, m_rval;
  logic        sh_rw, sh_owner;
  logic [31:0] sh_addr, sh_wdata;
  logic [31:0] exp_rdata [2];

  // requester agents (index 0 = C, 1 = D)
  bit          a_req [2];
  bit          a_rw  [2];
  logic [31:0] a_addr [2];
  logic [31:0] a_wdata [2];
  bit          pending [2];
  bit          ack_seen [2];

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cur_cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active     = 1'b0;
    m_gt         = -100;
    m_last       = 1'b1;
    sh_rw        = 1'b1;
    sh_owner     = 1'b0;
    sh_addr      = '0;
    sh_wdata     = '0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  // Compare this cycle's outputs, then advance the model by one cycle.
  task automatic model_step(input int n);
    int rel;
    bit e_en, e_busy, e_done, w;
    rel = n - m_gt;
    if (m_active && rel == 1) begin
      sh_rw    = m_rw;
      sh_addr  = m_addr;
      sh_wdata = m_wdata;
      sh_owner = m_port;
      if (m_rw) m_rval = model_mem[m_addr[5:2]];
      else      model_mem[m_addr[5:2]] = m_wdata;
    end
    e_en   = m_active && rel == 1;
    e_busy = m_active && rel >= 1;
    e_done = m_active && rel == LAT + 2;
    if (e_done && m_rw) exp_rdata[m_port] = m_rval;

    check_value("c_ack", 32'(c_ack), 32'(e_done && !m_port));
    check_value("d_ack", 32'(d_ack), 32'(e_done && m_port));
    check_value("mem_en", 32'(mem_en), 32'(e_en));
    check_value("busy", 32'(busy), 32'(e_busy));
    check_value("owner", 32'(owner), 32'(sh_owner));
    check_value("mem_rw", 32'(mem_rw), 32'(sh_rw));
    check_value("mem_addr", mem_addr, sh_addr);
    check_value("mem_wdata", mem_wdata, sh_wdata);
    check_value("c_rdata", c_rdata, exp_rdata[0]);
    check_value("d_rdata", d_rdata, exp_rdata[1]);

    // memory responder, driven by the DUT's memory port
    if (mem_en === 1'b1) begin
      if (mem_rw === 1'b1) begin
        resp_cycle = n + LAT;
        resp_data  = mem_arr[mem_addr[5:2]];
      end else begin
        mem_arr[mem_addr[5:2]] = mem_wdata;
      end
    end

    if (e_done) begin
      m_active         = 1'b0;
      m_last           = m_port;
      ack_seen[m_port] = 1'b1;
      n_txn++;
      $display("txn %0d cycle %0d port %s %s addr=%h data=%h", n_txn, n,
               m_port ? "D" : "C", m_rw ? "RD" : "WR", m_addr, m_rw ? m_rval : m_wdata);
    end else if (!m_active && (c_req || d_req)) begin
      if (c_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w = (m_last == 1'b0);
`else
        w = 1'b0;
`endif
      end else begin
        w = d_req;
      end
      m_active = 1'b1;
      m_gt     = n;
      m_port   = w;
      m_rw     = w ? d_rw : c_rw;
      m_addr   = w ? d_addr : c_addr;
      m_wdata  = w ? d_wdata : c_wdata;
    end
    if (reset) model_reset();
  endtask

  // One requester: raise random commands, hold until ack, and drop req in the
  // cycle after the ack. It may drop req or scramble its command after the
  // grant; the arbiter must ignore both.
  task automatic agent_step(input int p, input int n, input bit rst_now);
    int rel_p;
    int r;
    rel_p = (m_active && m_port == p[0]) ? (n - m_gt) : -1;
    if (rst_now) begin
      a_req[p] = 1'b0; pending[p] = 1'b0; ack_seen[p] = 1'b0;
    end else if (ack_seen[p]) begin
      a_req[p] = 1'b0; pending[p] = 1'b0; ack_seen[p] = 1'b0;
    end else if (!pending[p]) begin
      if ($urandom_range(0, 2) == 0) begin
        a_req[p]   = 1'b1;
        pending[p] = 1'b1;
        a_rw[p]    = 1'($urandom_range(0, 1));
        a_addr[p]  = 32'($urandom_range(0, 15)) << 2;
        a_wdata[p] = $urandom;
      end
    end else if (rel_p >= 1) begin
      r = int'($urandom_range(0, 15));
      if (r == 0) begin
        a_req[p] = 1'b0;
      end else if (r < 4) begin
        a_rw[p]    = ~a_rw[p];
        a_addr[p]  = $urandom;
        a_wdata[p] = $urandom;
      end
    end
  endtask

  initial begin
    bit rst_now;
    reset = 1'b1;
    c_req = 0; c_rw = 1; c_addr = '0; c_wdata = '0;
    d_req = 0; d_rw = 1; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      mem_arr[i]   = $urandom;
      model_mem[i] = mem_arr[i];
    end
    for (int p = 0; p < 2; p++) begin
      a_req[p] = 0; a_rw[p] = 1; a_addr[p] = '0; a_wdata[p] = '0;
      pending[p] = 0; ack_seen[p] = 0;
    end
    model_reset();

    for (int n = 0; n < NCYC; n++) begin
      @(posedge clock);
      #1;
      cur_cyc = n;
      rst_now = (n < 2);
      if (!rst_now && m_active && (n - m_gt) >= 2 && (n - m_gt) <= LAT + 1)
        rst_now = ($urandom_range(0, 39) == 0);
      if (!rst_now)
        rst_now = ($urandom_range(0, 299) == 0);
      reset = rst_now;
      agent_step(0, n, rst_now);
      agent_step(1, n, rst_now);
      c_req = a_req[0]; c_rw = a_rw[0]; c_addr = a_addr[0]; c_wdata = a_wdata[0];
      d_req = a_req[1]; d_rw = a_rw[1]; d_addr = a_addr[1]; d_wdata = a_wdata[1];
      mem_rdata = (n == resp_cycle) ? resp_data : $urandom;
      @(negedge clock);
      model_step(n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
